// File: rtl/cla_pkg.sv
// Shared definitions for the serial carry-look-ahead adder.
package cla_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } cla_ser_state_t;

endpackage

// File: rtl/cla_serial_adder_cla4_slice.sv
// 4-bit generate/propagate carry-look-ahead slice, purely combinational.
module cla4_slice
  import cla_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a4,
  input  logic [NIBBLE_W-1:0] b4,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s4,
  output logic                co
);

  logic [NIBBLE_W-1:0] g;
  logic [NIBBLE_W-1:0] p;
  logic [NIBBLE_W:0]   c;

  // Look-ahead carries computed directly from generate/propagate terms.
  always_comb begin
    g    = a4 & b4;
    p    = a4 ^ b4;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    s4   = p ^ c[NIBBLE_W-1:0];
    co   = c[NIBBLE_W];
  end

endmodule

// File: rtl/cla_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one nibble per clock through a 4-bit CLA slice,
// carry held in a register between nibbles, valid/ready on both sides.
// Optional macro CLA_SERIAL_OVF_EN enables the registered signed-overflow flag;
// without it ovf is tied low.
module cla_serial_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIB = WIDTH / NIBBLE_W;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  generate
    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_width_chk
      $error("cla_serial_adder: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  cla_ser_state_t state_q, state_d;

  logic [WIDTH-1:0]    a_q;
  logic [WIDTH-1:0]    b_q;
  logic [CW-1:0]       nib_cnt;
  logic                carry_q;
  logic [NIBBLE_W-1:0] a4;
  logic [NIBBLE_W-1:0] b4;
  logic [NIBBLE_W-1:0] s4;
  logic                co;
  logic                accept;
  logic                last;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;
  assign last      = (state_q == RUN) && (nib_cnt == CW'(NIB - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: accept, NIB nibble steps, then hold until consumed.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (nib_cnt == CW'(NIB - 1)) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Select the current operand nibble for the slice.
  always_comb begin
    a4 = '0;
    b4 = '0;
    for (int unsigned i = 0; i < NIB; i++) begin
      if (nib_cnt == CW'(i)) begin
        a4 = a_q[i*NIBBLE_W +: NIBBLE_W];
        b4 = b_q[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  cla4_slice u_slice (
    .a4 (a4),
    .b4 (b4),
    .ci (carry_q),
    .s4 (s4),
    .co (co)
  );

  // Operand capture, nibble counter and inter-nibble carry register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      nib_cnt <= '0;
      carry_q <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      nib_cnt <= '0;
      carry_q <= cin;
    end else if (state_q == RUN) begin
      nib_cnt <= nib_cnt + CW'(1);
      carry_q <= co;
    end
  end

  // Result registers: one sum nibble per RUN step, carry-out on the last step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= '0;
      cout <= 1'b0;
    end else if (state_q == RUN) begin
      for (int unsigned i = 0; i < NIB; i++) begin
        if (nib_cnt == CW'(i)) sum[i*NIBBLE_W +: NIBBLE_W] <= s4;
      end
      if (last) cout <= co;
    end
  end

`ifdef CLA_SERIAL_OVF_EN
  // Signed overflow, registered alongside cout; s4 MSB is the final sum MSB here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    ovf <= 1'b0;
    else if (last) ovf <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (s4[NIBBLE_W-1] != a_q[WIDTH-1]);
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_cla_serial_adder.sv
// Testbench for cla_serial_adder: directed cases at WIDTH=16 and randomized
// traffic with random backpressure at WIDTH=16 and WIDTH=4.
module tb_cla_serial_adder;

  localparam int NRAND = 1000;

  logic clk = 1'b0;
  logic rst_n;

  logic        iv16, ir16, ov16, or16, cin16, cout16, ovf16;
  logic [15:0] a16, b16, sum16;
  logic        iv4, ir4, ov4, or4, cin4, cout4, ovf4;
  logic [3:0]  a4, b4, sum4;

  int errors = 0;
  int checks = 0;

  logic [17:0] q16[$];
  logic [5:0]  q4[$];

  always #5 clk = ~clk;

  cla_serial_adder #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .cin(cin16), .out_valid(ov16), .out_ready(or16), .sum(sum16), .cout(cout16), .ovf(ovf16)
  );

  cla_serial_adder #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .cin(cin4), .out_valid(ov4), .out_ready(or4), .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Signed overflow of a w-bit add, from operand and result sign bits.
  function automatic logic ref_ovf(input int w, input logic [15:0] x, input logic [15:0] y,
                                   input logic [15:0] s);
`ifdef CLA_SERIAL_OVF_EN
    return (x[w-1] == y[w-1]) && (s[w-1] != x[w-1]);
`else
    return 1'b0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send16(input logic [15:0] x, input logic [15:0] y, input logic c);
    int guard = 0;
    a16 = x; b16 = y; cin16 = c; iv16 = 1'b1;
    while (!ir16 && guard < 50) begin tick(); guard++; end
    if (!ir16) check("send16_timeout", 32'd0, 32'd1);
    tick();
    iv16 = 1'b0;
  endtask

  task automatic wait_valid16(output int n);
    n = 0;
    while (!ov16 && n < 50) begin tick(); n++; end
    if (!ov16) check("wait_valid16_timeout", 32'd0, 32'd1);
  endtask

  task automatic expect16(input string tag, input logic [15:0] s, input logic c,
                          input logic [15:0] x, input logic [15:0] y);
    check({tag, "_sum"}, 32'(sum16), 32'(s));
    check({tag, "_cout"}, 32'(cout16), 32'(c));
    check({tag, "_ovf"}, 32'(ovf16), 32'(ref_ovf(16, x, y, s)));
  endtask

  task automatic pop16(input string tag);
    or16 = 1'b1;
    tick();
    or16 = 1'b0;
    check({tag, "_in_ready"}, 32'(ir16), 32'd1);
    check({tag, "_out_valid"}, 32'(ov16), 32'd0);
  endtask

  task automatic random16();
    logic [15:0] x, y;
    logic        c, rdy;
    logic [16:0] full;
    int          g;
    for (int i = 0; i < NRAND; i++) begin
      x = 16'($urandom); y = 16'($urandom); c = 1'($urandom);
      a16 = x; b16 = y; cin16 = c; iv16 = 1'b1;
      g = 0;
      do begin
        @(negedge clk); rdy = ir16;
        @(posedge clk); #1; g++;
      end while (!rdy && g < 100);
      if (!rdy) begin check("r16_accept_timeout", 32'd0, 32'd1); iv16 = 1'b0; return; end
      full = 17'(x) + 17'(y) + 17'(c);
      q16.push_back({ref_ovf(16, x, y, full[15:0]), full});
      iv16 = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic random4();
    logic [3:0] x, y;
    logic       c, rdy;
    logic [4:0] full;
    int         g;
    for (int i = 0; i < NRAND; i++) begin
      x = 4'($urandom); y = 4'($urandom); c = 1'($urandom);
      a4 = x; b4 = y; cin4 = c; iv4 = 1'b1;
      g = 0;
      do begin
        @(negedge clk); rdy = ir4;
        @(posedge clk); #1; g++;
      end while (!rdy && g < 100);
      if (!rdy) begin check("r4_accept_timeout", 32'd0, 32'd1); iv4 = 1'b0; return; end
      full = 5'(x) + 5'(y) + 5'(c);
      q4.push_back({ref_ovf(4, {12'd0, x}, {12'd0, y}, {12'd0, full[3:0]}), full});
      iv4 = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic consume16();
    int          got = 0;
    int          idle = 0;
    logic [17:0] e;
    while (got < NRAND && idle < 2000) begin
      or16 = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (ov16 && or16) begin
        if (q16.size() == 0) check("r16_unexpected_result", 32'd1, 32'd0);
        else begin
          e = q16.pop_front();
          check("r16_result", 32'({ovf16, cout16, sum16}), 32'(e));
        end
        got++; idle = 0;
      end else idle++;
      @(posedge clk); #1;
    end
    if (got < NRAND) check("r16_result_count", 32'(got), 32'(NRAND));
    or16 = 1'b0;
  endtask

  task automatic consume4();
    int         got = 0;
    int         idle = 0;
    logic [5:0] e;
    while (got < NRAND && idle < 2000) begin
      or4 = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (ov4 && or4) begin
        if (q4.size() == 0) check("r4_unexpected_result", 32'd1, 32'd0);
        else begin
          e = q4.pop_front();
          check("r4_result", 32'({ovf4, cout4, sum4}), 32'(e));
        end
        got++; idle = 0;
      end else idle++;
      @(posedge clk); #1;
    end
    if (got < NRAND) check("r4_result_count", 32'(got), 32'(NRAND));
    or4 = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    iv16 = 1'b0; or16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
    iv4  = 1'b0; or4  = 1'b0; a4  = '0; b4  = '0; cin4  = 1'b0;

    // Reset state, checked before any clock edge.
    #3;
    check("rst_in_ready", 32'(ir16), 32'd1);
    check("rst_out_valid", 32'(ov16), 32'd0);
    check("rst_sum", 32'(sum16), 32'd0);
    check("rst_cout", 32'(cout16), 32'd0);
    check("rst_ovf", 32'(ovf16), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // 1: plain add, latency measured from the acceptance edge.
    send16(16'h1234, 16'h4321, 1'b0);
    check("t1_valid_early", 32'(ov16), 32'd0);
    wait_valid16(n);
    check("t1_latency", 32'(n), 32'd4);
    expect16("t1", 16'h5555, 1'b0, 16'h1234, 16'h4321);
    pop16("t1_pop");

    // 2: carry-in ripples through every nibble.
    send16(16'hFFFF, 16'h0000, 1'b1);
    wait_valid16(n);
    expect16("t2", 16'h0000, 1'b1, 16'hFFFF, 16'h0000);
    pop16("t2_pop");

    // 3: signed overflow case.
    send16(16'h7FFF, 16'h0001, 1'b0);
    wait_valid16(n);
    expect16("t3", 16'h8000, 1'b0, 16'h7FFF, 16'h0001);
    pop16("t3_pop");

    // 4: backpressure with new operands offered throughout.
    send16(16'h1111, 16'h2222, 1'b0);
    wait_valid16(n);
    a16 = 16'hAAAA; b16 = 16'h5555; cin16 = 1'b1; iv16 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_sum", 32'(sum16), 32'h3333);
      check("t4_hold_cout", 32'(cout16), 32'd0);
      check("t4_hold_in_ready", 32'(ir16), 32'd0);
      check("t4_hold_out_valid", 32'(ov16), 32'd1);
      tick();
    end
    iv16 = 1'b0;
    pop16("t4_pop");

    // 5: async reset during the second RUN cycle aborts the operation.
    send16(16'h1234, 16'h1111, 1'b0);
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_sum", 32'(sum16), 32'd0);
    check("t5_rst_cout", 32'(cout16), 32'd0);
    check("t5_rst_ovf", 32'(ovf16), 32'd0);
    check("t5_rst_out_valid", 32'(ov16), 32'd0);
    check("t5_rst_in_ready", 32'(ir16), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("t5_no_aborted_result", 32'(ov16), 32'd0);
    send16(16'h00FF, 16'h0001, 1'b0);
    wait_valid16(n);
    expect16("t5", 16'h0100, 1'b0, 16'h00FF, 16'h0001);
    pop16("t5_pop");

    // 6: randomized traffic with random backpressure on both widths.
    fork
      random16();
      consume16();
      random4();
      consume4();
    join
    check("r16_leftover", 32'(q16.size()), 32'd0);
    check("r4_leftover", 32'(q4.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
